// File: rtl/bus_pkg.sv
// Shared bus types: owner encoding used by the arbiter and the bus address/data
// muxes, plus the arbiter FSM state encoding.
package bus_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_INIT1 = 2'd1,
    OWNER_INIT2 = 2'd2,
    OWNER_SPLIT = 2'd3
  } owner_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_OWN_I1    = 3'd1,
    ST_OWN_I2    = 3'd2,
    ST_OWN_SPLIT = 3'd3,
    ST_TURN      = 3'd4
  } arb_state_e;

  // The round-robin pointer only ever names one of the two initiators.
  function automatic owner_e other_init(input owner_e o);
    return (o == OWNER_INIT1) ? OWNER_INIT2 : OWNER_INIT1;
  endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational pick of the next bus owner from already-masked eligibility.
// Ports:
//   init1_elig / init2_elig  initiator request, masked while its split is pending
//   split_elig               split target request qualified by a pending split
//   rr_ptr                   initiator favoured on a tie when ROUND_ROBIN=1
//   pick                     chosen owner, OWNER_NONE when nothing is eligible
module arb_priority_pick
  import bus_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic   init1_elig,
  input  logic   init2_elig,
  input  logic   split_elig,
  input  owner_e rr_ptr,
  output owner_e pick
);

  always_comb begin
    pick = OWNER_NONE;
    if (split_elig) begin
      pick = OWNER_SPLIT;
    end else if (init1_elig && init2_elig) begin
      pick = ROUND_ROBIN ? rr_ptr : OWNER_INIT1;
    end else if (init1_elig) begin
      pick = OWNER_INIT1;
    end else if (init2_elig) begin
      pick = OWNER_INIT2;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Central arbiter for the shared serial bus: grants two initiators and the split
// target, tracks one outstanding split and abandons it after SPLIT_TIMEOUT cycles.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   init1_req, init2_req          initiator requests, held for the transaction
//   split_target_req              split target wants to return split data
//   split_ack                     current read accepted as split (1-cycle pulse)
//   init1_grant, init2_grant,
//   split_target_grant            registered grants, at most one high
//   bus_owner                     owner select for the bus muxes
//   split_owner                   initiator awaiting split data, NONE if none
//   split_timeout                 1-cycle pulse when a pending split is abandoned
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no owner; arbitrate among eligible requests
// ST_OWN_I1    | initiator 1 holds the bus
// ST_OWN_I2    | initiator 2 holds the bus
// ST_OWN_SPLIT | split target returning data for split_owner
// ST_TURN      | one dead cycle between owners, all grants low
module bus_arbiter
  import bus_pkg::*;
#(
  parameter bit ROUND_ROBIN   = 1'b0,
  parameter int SPLIT_TIMEOUT = 256
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   init1_req,
  input  logic   init2_req,
  input  logic   split_target_req,
  input  logic   split_ack,
  output logic   init1_grant,
  output logic   init2_grant,
  output logic   split_target_grant,
  output owner_e bus_owner,
  output owner_e split_owner,
  output logic   split_timeout
);

  localparam int               CNT_W    = $clog2(SPLIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SPLIT_TIMEOUT - 1);

  arb_state_e       state;
  owner_e           rr_ptr;
  owner_e           pick;
  logic [CNT_W-1:0] to_cnt;
  logic             split_pending;
  logic             init1_elig;
  logic             init2_elig;
  logic             split_elig;
  logic             split_grant_now;
  logic             to_count_en;

  assign split_pending = (split_owner != OWNER_NONE);
  assign init1_elig    = init1_req && (split_owner != OWNER_INIT1);
  assign init2_elig    = init2_req && (split_owner != OWNER_INIT2);
  assign split_elig    = split_target_req && split_pending;

  // A timeout landing on the same edge as the split grant loses to the grant.
  assign split_grant_now = (state == ST_IDLE) && (pick == OWNER_SPLIT);
  assign to_count_en     = split_pending && (state != ST_OWN_SPLIT) && !split_grant_now;

  arb_priority_pick #(
    .ROUND_ROBIN(ROUND_ROBIN)
  ) u_pick (
    .init1_elig(init1_elig),
    .init2_elig(init2_elig),
    .split_elig(split_elig),
    .rr_ptr    (rr_ptr),
    .pick      (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      init1_grant        <= 1'b0;
      init2_grant        <= 1'b0;
      split_target_grant <= 1'b0;
      bus_owner          <= OWNER_NONE;
      split_owner        <= OWNER_NONE;
      split_timeout      <= 1'b0;
      rr_ptr             <= OWNER_INIT1;
      to_cnt             <= '0;
    end else begin
      split_timeout <= 1'b0;

      // split_ack is only honoured with no split pending, so the timeout
      // branch and the ack branch below never write split_owner together.
      if (to_count_en) begin
        if (to_cnt == CNT_LAST) begin
          split_owner   <= OWNER_NONE;
          split_timeout <= 1'b1;
          to_cnt        <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          case (pick)
            OWNER_INIT1: begin
              state       <= ST_OWN_I1;
              init1_grant <= 1'b1;
              bus_owner   <= OWNER_INIT1;
              rr_ptr      <= other_init(rr_ptr);
            end
            OWNER_INIT2: begin
              state       <= ST_OWN_I2;
              init2_grant <= 1'b1;
              bus_owner   <= OWNER_INIT2;
              rr_ptr      <= other_init(rr_ptr);
            end
            OWNER_SPLIT: begin
              state              <= ST_OWN_SPLIT;
              split_target_grant <= 1'b1;
              bus_owner          <= OWNER_SPLIT;
            end
            default: ;
          endcase
        end

        // split_ack is checked first: ack with req falling counts as a split.
        ST_OWN_I1: begin
          if (split_ack && !split_pending) begin
            init1_grant <= 1'b0;
            bus_owner   <= OWNER_NONE;
            split_owner <= OWNER_INIT1;
            to_cnt      <= '0;
            state       <= ST_TURN;
          end else if (!init1_req) begin
            init1_grant <= 1'b0;
            bus_owner   <= OWNER_NONE;
            state       <= ST_TURN;
          end
        end

        ST_OWN_I2: begin
          if (split_ack && !split_pending) begin
            init2_grant <= 1'b0;
            bus_owner   <= OWNER_NONE;
            split_owner <= OWNER_INIT2;
            to_cnt      <= '0;
            state       <= ST_TURN;
          end else if (!init2_req) begin
            init2_grant <= 1'b0;
            bus_owner   <= OWNER_NONE;
            state       <= ST_TURN;
          end
        end

        ST_OWN_SPLIT: begin
          if (!split_target_req) begin
            split_target_grant <= 1'b0;
            bus_owner          <= OWNER_NONE;
            split_owner        <= OWNER_NONE;
            state              <= ST_TURN;
          end
        end

        ST_TURN: state <= ST_IDLE;

        default: begin
          state              <= ST_IDLE;
          init1_grant        <= 1'b0;
          init2_grant        <= 1'b0;
          split_target_grant <= 1'b0;
          bus_owner          <= OWNER_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: a fixed-priority and a round-robin instance (both with
// an 8-cycle split timeout) share one stimulus stream; each is checked every
// cycle against a behavioural model of the arbitration rules.
module tb_bus_arbiter;

  localparam int TO = 8;

  logic clk;
  logic rst_n;
  logic r1, r2, rs, ack;

  logic       f_g1, f_g2, f_gs, f_to;
  logic [1:0] f_bo, f_so;
  logic       r_g1, r_g2, r_gs, r_to;
  logic [1:0] r_bo, r_so;

  int compared   = 0;
  int mismatched = 0;

  // owner: 0 none, 1 init1, 2 init2, 3 split target; turn marks the dead cycle;
  // pend: initiator waiting for split data (0 none); age: cycles the split waited.
  typedef struct {
    int owner;
    bit turn;
    int pend;
    int age;
    int rr;
    bit tpulse;
  } mdl_t;

  mdl_t mf, mr;

  bus_arbiter #(.ROUND_ROBIN(1'b0), .SPLIT_TIMEOUT(TO)) u_fix (
    .clk(clk), .rst_n(rst_n),
    .init1_req(r1), .init2_req(r2), .split_target_req(rs), .split_ack(ack),
    .init1_grant(f_g1), .init2_grant(f_g2), .split_target_grant(f_gs),
    .bus_owner(f_bo), .split_owner(f_so), .split_timeout(f_to)
  );

  bus_arbiter #(.ROUND_ROBIN(1'b1), .SPLIT_TIMEOUT(TO)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .init1_req(r1), .init2_req(r2), .split_target_req(rs), .split_ack(ack),
    .init1_grant(r_g1), .init2_grant(r_g2), .split_target_grant(r_gs),
    .bus_owner(r_bo), .split_owner(r_so), .split_timeout(r_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.owner = 0; m.turn = 1'b0; m.pend = 0; m.age = 0; m.rr = 1; m.tpulse = 1'b0;
    return m;
  endfunction

  function automatic mdl_t step(input mdl_t s, input bit rrm,
                                input bit q1, input bit q2, input bit qs, input bit qa);
    mdl_t n;
    bit   split_win, e1, e2, own_req;
    n = s;
    n.tpulse  = 1'b0;
    split_win = 1'b0;
    if (s.turn) begin
      n.turn = 1'b0;
    end else if (s.owner == 0) begin
      e1 = q1 && (s.pend != 1);
      e2 = q2 && (s.pend != 2);
      if (s.pend != 0 && qs) begin
        n.owner   = 3;
        split_win = 1'b1;
      end else if (e1 || e2) begin
        if (e1 && e2) n.owner = rrm ? s.rr : 1;
        else          n.owner = e1 ? 1 : 2;
        n.rr = 3 - s.rr;
      end
    end else if (s.owner == 3) begin
      if (!qs) begin
        n.pend = 0; n.owner = 0; n.turn = 1'b1;
      end
    end else begin
      own_req = (s.owner == 1) ? q1 : q2;
      if (qa && s.pend == 0) begin
        n.pend = s.owner; n.age = 0; n.owner = 0; n.turn = 1'b1;
      end else if (!own_req) begin
        n.owner = 0; n.turn = 1'b1;
      end
    end
    if (s.pend != 0 && !(s.owner == 3 && !s.turn) && !split_win) begin
      if (s.age == TO - 1) begin
        n.pend = 0; n.tpulse = 1'b1; n.age = 0;
      end else begin
        n.age = s.age + 1;
      end
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_dut(input string nm, input mdl_t m,
                         input logic g1, input logic g2, input logic gs,
                         input logic [1:0] bo, input logic [1:0] so, input logic to);
    logic [1:0] from_grants;
    from_grants = gs ? 2'd3 : g2 ? 2'd2 : g1 ? 2'd1 : 2'd0;
    chk({nm, ".init1_grant"},   4'(g1), 4'(m.owner == 1));
    chk({nm, ".init2_grant"},   4'(g2), 4'(m.owner == 2));
    chk({nm, ".split_grant"},   4'(gs), 4'(m.owner == 3));
    chk({nm, ".bus_owner"},     4'(bo), 4'(m.owner));
    chk({nm, ".split_owner"},   4'(so), 4'(m.pend));
    chk({nm, ".split_timeout"}, 4'(to), 4'(m.tpulse));
    chk({nm, ".onehot0"},       4'($onehot0({g1, g2, gs})), 4'd1);
    chk({nm, ".owner_vs_grant"}, 4'(bo), 4'(from_grants));
  endtask

  task automatic check_all();
    chk_dut("fix", mf, f_g1, f_g2, f_gs, f_bo, f_so, f_to);
    chk_dut("rr",  mr, r_g1, r_g2, r_gs, r_bo, r_so, r_to);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      mf = step(mf, 1'b0, r1, r2, rs, ack);
      mr = step(mr, 1'b1, r1, r2, rs, ack);
    end
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic split_via_init1();
    r1 = 1'b1; ticks(2);
    ack = 1'b1; tick();
    ack = 1'b0; r1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; r1 = 1'b0; r2 = 1'b0; rs = 1'b0; ack = 1'b0;
    mf = mdl_reset(); mr = mdl_reset();
    ticks(2);
    rst_n = 1'b1;
    tick();

    // single request: grant one cycle after sampling, then TURN, then IDLE
    r1 = 1'b1; tick();
    chk("t1.fix_grant", 4'(f_g1), 4'd1);
    chk("t1.fix_owner", 4'(f_bo), 4'd1);
    tick();
    r1 = 1'b0; tick();
    chk("t1.fix_drop", 4'(f_g1), 4'd0);
    ticks(2);

    // simultaneous requests, two rounds
    for (int rnd = 0; rnd < 2; rnd++) begin
      r1 = 1'b1; r2 = 1'b1; ticks(3);
      if (f_g1) r1 = 1'b0; else r2 = 1'b0;
      if (r_g1) r1 = 1'b0; else if (r_g2) r2 = 1'b0;
      ticks(4);
      r1 = 1'b0; r2 = 1'b0; ticks(3);
    end

    // split by init2, init1 completes, split target returns data
    r2 = 1'b1; ticks(2);
    ack = 1'b1; tick();
    chk("t3.fix_split_owner", 4'(f_so), 4'd2);
    ack = 1'b0; r2 = 1'b0;
    r1 = 1'b1; ticks(3);
    r1 = 1'b0; ticks(1);
    rs = 1'b1; ticks(3);
    rs = 1'b0; ticks(3);

    // split pending with init2 held high: masked until timeout clears it
    r2 = 1'b1; ticks(2);
    ack = 1'b1; tick();
    ack = 1'b0; ticks(12);
    r2 = 1'b0; ticks(3);

    // timeout with no split target, later split_target_req ignored
    split_via_init1();
    ticks(10);
    rs = 1'b1; ticks(3);
    rs = 1'b0; ticks(2);

    // split grant lands on the same edge the timeout would fire
    split_via_init1();
    ticks(7);
    rs = 1'b1; tick();
    chk("t5.fix_grant_beats_to", 4'(f_gs), 4'd1);
    ticks(2);
    rs = 1'b0; ticks(3);

    // asynchronous reset while init1 owns the bus
    r1 = 1'b1; ticks(2);
    #3 rst_n = 1'b0;
    #1;
    mf = mdl_reset(); mr = mdl_reset();
    chk("t6.fix_grant_rst", 4'(f_g1), 4'd0);
    chk("t6.fix_owner_rst", 4'(f_bo), 4'd0);
    check_all();
    tick();
    rst_n = 1'b1; r1 = 1'b0;
    ticks(2);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(5) == 0) r1 = ~r1;
      if ($urandom_range(5) == 0) r2 = ~r2;
      if ($urandom_range(4) == 0) rs = ~rs;
      ack = ($urandom_range(5) == 0);
      tick();
    end
    r1 = 1'b0; r2 = 1'b0; rs = 1'b0; ack = 1'b0;
    ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
